cv32e40p_ldm_responder: RTL
===========================

# cv32e40p_ldm_responder

Alarm responder for the loop-detection monitor. Consumes the level `alarm_i` produced by the detector and raises a registered interrupt request to the core. It tracks the acknowledge and handler-completion handshake, with a timeout on each phase. Repeated alarms, or a missing or stuck handler, escalate to a sticky lockdown that only reset clears. It sits between the detector output and the core's interrupt/fetch-control logic.

## Interface
Parameters:
- `ACK_TIMEOUT`, default 64: maximum extra cycles `irq_o` may stay unacknowledged.
- `HANDLER_TIMEOUT`, default 1024: maximum extra cycles between acknowledge and `handler_done_i`.
- `MAX_ALARMS`, default 3: number of alarms since reset that forces lockdown (≥1).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `alarm_i`  in  1  level alarm from the detector.
- `irq_ack_i`  in  1  one-cycle pulse: core has taken the interrupt.
- `handler_done_i`  in  1  one-cycle pulse: recovery handler has finished (return from handler).
- `irq_o`  out  1  interrupt request, registered.
- `handling_o`  out  1  high while the handler is running (HANDLE state).
- `lockdown_o`  out  1  sticky escalation; core must halt fetch.
- `alarm_count_o`  out  $clog2(MAX_ALARMS+1)  alarms accepted since reset, saturating.

## Operation
- FSM states: IDLE, REQ, HANDLE, REARM, LOCK.
- All outputs are decoded from registered state, so there is no combinational input-to-output path.
  - `irq_o` = (state==REQ)
  - `handling_o` = (state==HANDLE)
  - `lockdown_o` = (state==LOCK)
- IDLE, when `alarm_i`=1:
  - `alarm_count_o` increments.
  - If the incremented value equals MAX_ALARMS, go to LOCK.
  - Otherwise go to REQ and load the timer with ACK_TIMEOUT.
- REQ:
  - `irq_ack_i`=1 → HANDLE; load the timer with HANDLER_TIMEOUT.
  - Otherwise, if timer==0 → LOCK; else decrement the timer.
  - Acknowledge wins over a simultaneous timeout.
- HANDLE:
  - `handler_done_i`=1 → REARM.
  - Otherwise, if timer==0 → LOCK; else decrement the timer.
  - Done wins over a simultaneous timeout.
  - `alarm_i` is ignored in this state.
- REARM: go to IDLE once `alarm_i`=0. A still-asserted alarm level is never counted twice.
- LOCK: absorbing state; only `rst_n` leaves it. Inputs are ignored.
- `irq_ack_i` or `handler_done_i` arriving in any state other than REQ or HANDLE respectively is ignored.
- Width rules:
  - Timer width is $clog2(max(ACK_TIMEOUT,HANDLER_TIMEOUT)+1).
  - The timer never wraps; decrement happens only when it is non-zero.
  - `alarm_count_o` never exceeds MAX_ALARMS.
- MAX_ALARMS=1: the first alarm goes straight to LOCK; `irq_o` never rises.

## Timing
- Reset values: state IDLE, timer 0, `irq_o`=0, `handling_o`=0, `lockdown_o`=0, `alarm_count_o`=0. Reset takes effect immediately, including mid-REQ, mid-HANDLE and from LOCK.
- Alarm to request: `alarm_i` sampled high at edge n → `irq_o`=1 and count updated after edge n (1-cycle latency).
- Acknowledge: `irq_ack_i` sampled at edge m → `irq_o`=0 and `handling_o`=1 after edge m.
- Acknowledge timeout: REQ lasts at most ACK_TIMEOUT+1 cycles. `lockdown_o` rises ACK_TIMEOUT+1 cycles after `irq_o` rises if no acknowledge arrives. An acknowledge in the last REQ cycle (timer==0) is still accepted.
- Handler timeout: HANDLE lasts at most HANDLER_TIMEOUT+1 cycles, with the same last-cycle acceptance rule.
- REARM → IDLE: takes one cycle after `alarm_i` is sampled low. A new alarm needs `alarm_i` sampled high in IDLE, i.e. at least 2 cycles after the handler completes.

## Test plan
- **Single alarm, full handshake.** Defaults; pulse `alarm_i`; `irq_ack_i` 3 cycles after `irq_o` rises; `handler_done_i` 10 cycles later.
  → `irq_o` high exactly 3 cycles, then `handling_o` high exactly 10 cycles, then IDLE; `alarm_count_o`=1, `lockdown_o`=0.
- **Acknowledge timeout.** ACK_TIMEOUT=4; raise an alarm, never acknowledge.
  → `irq_o` high 5 cycles; `lockdown_o`=1 on the 6th cycle and stays high with stimulus toggling.
  - Variant: acknowledge on the 5th cycle → HANDLE, no lock.
- **Handler timeout.** HANDLER_TIMEOUT=8; acknowledge, never send done.
  → `handling_o` high 9 cycles, then `lockdown_o`=1.
- **Escalation.** MAX_ALARMS=3; run three complete alarm/handler sequences.
  → The first two produce `irq_o`. The third goes IDLE→LOCK with `irq_o` never rising; `alarm_count_o`=3.
- **Held alarm, no re-trigger.** Keep `alarm_i`=1 through the handshake and for 20 cycles after done.
  → Remains in REARM with `alarm_count_o`=1. Drop `alarm_i` for one cycle, then raise it → a second `irq_o` and count=2.
- **Async reset mid-operation.** Assert `rst_n`=0 between clock edges while in HANDLE, and again while in LOCK.
  → All outputs read 0 immediately, before the next edge; normal operation resumes after release.

Source files
------------

// File: rtl/cv32e40p_ldm_responder.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_ldm_responder
// Purpose  : Alarm responder for the loop-detection monitor. Converts the
//            detector's alarm level into a registered interrupt request,
//            tracks the acknowledge / handler-done handshake with a timeout
//            on each phase, and escalates to a sticky lockdown on repeated
//            alarms or a missing/stuck handler. Only reset leaves lockdown.
// Ports    : clk            - clock, rising edge
//            rst_n          - asynchronous active-low reset
//            alarm_i        - alarm level from the detector
//            irq_ack_i      - one-cycle pulse, core took the interrupt
//            handler_done_i - one-cycle pulse, recovery handler finished
//            irq_o          - interrupt request (registered)
//            handling_o     - handler running
//            lockdown_o     - sticky escalation, core must halt fetch
//            alarm_count_o  - alarms accepted since reset (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module cv32e40p_ldm_responder #(
  parameter int ACK_TIMEOUT     = 64,
  parameter int HANDLER_TIMEOUT = 1024,
  parameter int MAX_ALARMS      = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              alarm_i,
  input  logic                              irq_ack_i,
  input  logic                              handler_done_i,
  output logic                              irq_o,
  output logic                              handling_o,
  output logic                              lockdown_o,
  output logic [$clog2(MAX_ALARMS+1)-1:0]   alarm_count_o
);

  localparam int c_timer_max = (ACK_TIMEOUT > HANDLER_TIMEOUT) ? ACK_TIMEOUT : HANDLER_TIMEOUT;
  // A zero-cycle timeout still needs a one-bit timer to hold the value 0.
  localparam int c_timer_w   = (c_timer_max > 0) ? $clog2(c_timer_max + 1) : 1;
  localparam int c_count_w   = $clog2(MAX_ALARMS + 1);

  localparam logic [c_timer_w-1:0] c_ack_load = c_timer_w'(ACK_TIMEOUT);
  localparam logic [c_timer_w-1:0] c_hdl_load = c_timer_w'(HANDLER_TIMEOUT);
  localparam logic [c_count_w-1:0] c_max_cnt  = c_count_w'(MAX_ALARMS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_HANDLE = 3'd2,
    ST_REARM  = 3'd3,
    ST_LOCK   = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [c_timer_w-1:0]   timer_q, timer_d;
  logic [c_count_w-1:0]   count_q, count_d;
  logic [c_count_w-1:0]   count_inc;
  logic                   irq_q, handling_q, lockdown_q;

  // Count can never be at MAX_ALARMS while in IDLE (reaching it locks),
  // so the increment below cannot overflow the counter width.
  assign count_inc = count_q + 1'b1;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (alarm_i) begin
          if (count_q != c_max_cnt) begin
            count_d = count_inc;
          end
          if (count_inc == c_max_cnt) begin
            state_d = ST_LOCK;
          end else begin
            state_d = ST_REQ;
            timer_d = c_ack_load;
          end
        end
      end
      ST_REQ: begin
        // Acknowledge has priority over the expiring timer.
        if (irq_ack_i) begin
          state_d = ST_HANDLE;
          timer_d = c_hdl_load;
        end else if (timer_q == '0) begin
          state_d = ST_LOCK;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_HANDLE: begin
        // Completion has priority over the expiring timer.
        if (handler_done_i) begin
          state_d = ST_REARM;
        end else if (timer_q == '0) begin
          state_d = ST_LOCK;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_REARM: begin
        // Wait for the alarm level to drop so one alarm is counted once.
        if (!alarm_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCK: begin
        state_d = ST_LOCK;
      end
      default: begin
        state_d = ST_LOCK;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      count_q    <= '0;
      irq_q      <= 1'b0;
      handling_q <= 1'b0;
      lockdown_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      count_q    <= count_d;
      irq_q      <= (state_d == ST_REQ);
      handling_q <= (state_d == ST_HANDLE);
      lockdown_q <= (state_d == ST_LOCK);
    end
  end

  assign irq_o         = irq_q;
  assign handling_o    = handling_q;
  assign lockdown_o    = lockdown_q;
  assign alarm_count_o = count_q;

endmodule
`default_nettype wire
